// File: rtl/crosscorr_hls_deadlock_pkg.sv
// Shared types and helpers for the HLS deadlock reporter: FSM states,
// default report field widths and the run-counter width function.
package crosscorr_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    WATCH  = 2'd0,
    REPORT = 2'd1,
    HOLD   = 2'd2
  } dl_state_e;

  localparam int DEF_NUM_MON = 2;
  localparam int DEF_TS_W    = 32;

  typedef struct packed {
    logic [DEF_NUM_MON-1:0] mask;
    logic [DEF_TS_W-1:0]    ts;
  } dl_rpt_s;

  // Counter must hold the saturated value THRESH itself.
  function automatic int runcnt_w(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/crosscorr_hls_deadlock_runcnt.sv
// Saturating consecutive-blocked-cycle counter; hit flags the last cycle
// before the run reaches THRESH.
module crosscorr_hls_deadlock_runcnt
  import crosscorr_hls_deadlock_pkg::*;
#(
  parameter int THRESH = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inc,
  input  logic                          zero,
  output logic [runcnt_w(THRESH)-1:0]   cnt,
  output logic                          hit
);

  localparam int CW = runcnt_w(THRESH);
  localparam logic [CW-1:0] SAT_VAL = CW'(THRESH);
  localparam logic [CW-1:0] HIT_VAL = CW'(THRESH - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (inc && (cnt != SAT_VAL)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign hit = (cnt == HIT_VAL);

endmodule

// File: rtl/crosscorr_hls_deadlock_reporter.sv
// Declares a deadlock after THRESH consecutive blocked cycles and emits a
// single mask/timestamp record per deadlock over valid/ready.
module crosscorr_hls_deadlock_reporter
  import crosscorr_hls_deadlock_pkg::*;
#(
  parameter int NUM_MON = 2,
  parameter int THRESH  = 1024,
  parameter int TS_W    = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MON-1:0]            mon_block,
  input  logic                          clear,
  output logic                          rpt_valid,
  input  logic                          rpt_ready,
  output logic [NUM_MON-1:0]            rpt_mask,
  output logic [TS_W-1:0]               rpt_time,
  output logic                          deadlock,
  output logic [runcnt_w(THRESH)-1:0]   run_cnt
);

  dl_state_e            state_q, state_d;
  logic [TS_W-1:0]      cyc_q;
  logic [NUM_MON-1:0]   acc_q, acc_d;
  logic                 any_block;
  logic                 cnt_inc, cnt_zero, cnt_hit;
  logic                 trig;

  assign any_block = |mon_block;

  crosscorr_hls_deadlock_runcnt #(
    .THRESH (THRESH)
  ) u_runcnt (
    .clock (clock),
    .reset (reset),
    .inc   (cnt_inc),
    .zero  (cnt_zero),
    .cnt   (run_cnt),
    .hit   (cnt_hit)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_inc  = 1'b0;
    cnt_zero = 1'b0;
    trig     = 1'b0;
    unique case (state_q)
      WATCH: begin
        // clear outranks a blocked sample, including one that would trigger
        if (clear) begin
          cnt_zero = 1'b1;
          acc_d    = '0;
        end else if (any_block) begin
          cnt_inc = 1'b1;
          acc_d   = acc_q | mon_block;
          if (cnt_hit) begin
            trig    = 1'b1;
            state_d = REPORT;
          end
        end else begin
          cnt_zero = 1'b1;
          acc_d    = '0;
        end
      end
      REPORT: begin
        if (rpt_ready) state_d = HOLD;
      end
      HOLD: begin
        if (clear) begin
          state_d  = WATCH;
          cnt_zero = 1'b1;
          acc_d    = '0;
        end
      end
      default: state_d = WATCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= WATCH;
      cyc_q     <= '0;
      acc_q     <= '0;
      rpt_valid <= 1'b0;
      deadlock  <= 1'b0;
      rpt_mask  <= '0;
      rpt_time  <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_q + TS_W'(1);
      acc_q     <= acc_d;
      rpt_valid <= (state_d == REPORT);
      deadlock  <= (state_d != WATCH);
      if (trig) begin
        rpt_mask <= acc_q | mon_block;
        rpt_time <= cyc_q;
      end
    end
  end

endmodule

// File: tb/tb_crosscorr_hls_deadlock_reporter.sv
// Directed and randomized bench for the deadlock reporter against a
// run-length reference model.
module tb_crosscorr_hls_deadlock_reporter;

  localparam int NUM_MON = 2;
  localparam int THRESH  = 4;
  localparam int TS_W    = 8;
  localparam int CW      = $clog2(THRESH + 1);

  logic                clock;
  logic                reset;
  logic [NUM_MON-1:0]  mon_block;
  logic                clear;
  logic                rpt_valid;
  logic                rpt_ready;
  logic [NUM_MON-1:0]  rpt_mask;
  logic [TS_W-1:0]     rpt_time;
  logic                deadlock;
  logic [CW-1:0]       run_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int                  m_run;
  logic [NUM_MON-1:0]  m_acc;
  bit                  m_lock;
  bit                  m_pend;
  logic [NUM_MON-1:0]  m_mask;
  logic [TS_W-1:0]     m_time;
  logic [TS_W-1:0]     m_cyc;

  crosscorr_hls_deadlock_reporter #(
    .NUM_MON (NUM_MON),
    .THRESH  (THRESH),
    .TS_W    (TS_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mon_block (mon_block),
    .clear     (clear),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_mask  (rpt_mask),
    .rpt_time  (rpt_time),
    .deadlock  (deadlock),
    .run_cnt   (run_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_acc  = '0;
    m_lock = 0;
    m_pend = 0;
    m_mask = '0;
    m_time = '0;
    m_cyc  = '0;
  endtask

  // A deadlock is locked in once THRESH consecutive blocked samples are seen;
  // the record is outstanding until accepted, the lock until cleared.
  task automatic model_edge(input logic [NUM_MON-1:0] mb, input logic clr, input logic rdy);
    if (!m_lock) begin
      if (clr) begin
        m_run = 0;
        m_acc = '0;
      end else if (mb != 0) begin
        m_acc = m_acc | mb;
        m_run = m_run + 1;
        if (m_run == THRESH) begin
          m_lock = 1;
          m_pend = 1;
          m_mask = m_acc;
          m_time = m_cyc;
        end
      end else begin
        m_run = 0;
        m_acc = '0;
      end
    end else if (m_pend) begin
      if (rdy) m_pend = 0;
    end else if (clr) begin
      m_lock = 0;
      m_run  = 0;
      m_acc  = '0;
    end
    m_cyc = m_cyc + 1'b1;
  endtask

  task automatic check_all(input string where);
    chk({where, ".rpt_valid"}, 32'(rpt_valid), 32'(m_pend));
    chk({where, ".deadlock"},  32'(deadlock),  32'(m_lock));
    chk({where, ".run_cnt"},   32'(run_cnt),   32'(m_run));
    chk({where, ".rpt_mask"},  32'(rpt_mask),  32'(m_mask));
    chk({where, ".rpt_time"},  32'(rpt_time),  32'(m_time));
  endtask

  task automatic step(input string where, input logic [NUM_MON-1:0] mb,
                      input logic clr, input logic rdy);
    mon_block = mb;
    clear     = clr;
    rpt_ready = rdy;
    @(posedge clock);
    model_edge(mb, clr, rdy);
    #1;
    check_all(where);
  endtask

  initial begin
    reset     = 1'b1;
    mon_block = '0;
    clear     = 1'b0;
    rpt_ready = 1'b0;
    model_reset();
    #21;
    check_all("reset");
    #1 reset = 1'b0;

    // Two sub-threshold runs separated by one idle sample
    for (int i = 0; i < 3; i++) step("run_a", 2'b01, 1'b0, 1'b0);
    step("gap", 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("run_b", 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("idle_a", 2'b00, 1'b0, 1'b0);

    // Run starting at cyc=10 with ready already high
    step("trig1", 2'b01, 1'b0, 1'b1);
    step("trig1", 2'b01, 1'b0, 1'b1);
    step("trig1", 2'b10, 1'b0, 1'b1);
    step("trig1", 2'b10, 1'b0, 1'b1);
    chk("trig1_valid_const", 32'(rpt_valid), 32'd1);
    chk("trig1_mask_const",  32'(rpt_mask),  32'd3);
    chk("trig1_time_const",  32'(rpt_time),  32'd13);
    step("pulse_end", 2'b00, 1'b0, 1'b1);
    chk("pulse_end_const", 32'(rpt_valid), 32'd0);
    for (int i = 0; i < 3; i++) step("hold_a", 2'b11, 1'b0, 1'b1);

    // Clear in HOLD, then a fresh run with blocked inputs held
    step("clear_hold", 2'b11, 1'b1, 1'b0);
    chk("clear_hold_dl_const", 32'(deadlock), 32'd0);
    for (int i = 0; i < 3; i++) step("rearm", 2'b11, 1'b0, 1'b0);
    chk("rearm_no_early", 32'(rpt_valid), 32'd0);
    step("trig2", 2'b11, 1'b0, 1'b0);
    chk("trig2_valid_const", 32'(rpt_valid), 32'd1);

    // Backpressure; clear and mon_block ignored while reporting
    step("stall", 2'b00, 1'b0, 1'b0);
    step("stall", 2'b01, 1'b0, 1'b0);
    step("stall", 2'b00, 1'b1, 1'b0);
    step("stall", 2'b10, 1'b0, 1'b0);
    step("stall", 2'b00, 1'b0, 1'b0);
    step("accept", 2'b00, 1'b0, 1'b1);
    step("hold_b", 2'b00, 1'b0, 1'b0);
    step("clear_b", 2'b00, 1'b1, 1'b0);

    // Asynchronous reset while a record is outstanding
    for (int i = 0; i < 4; i++) step("pre_rst", 2'b01, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset = 1'b0;
    for (int i = 0; i < 20; i++) step("idle_b", 2'b00, 1'b0, 1'b0);

    // Randomized traffic, long enough to wrap the timestamp
    for (int i = 0; i < 600; i++) begin
      logic [NUM_MON-1:0] mb;
      logic clr, rdy;
      mb  = ($urandom_range(0, 4) == 0) ? 2'b00 : NUM_MON'($urandom_range(1, 3));
      clr = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step("rand", mb, clr, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
